// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the asynchronous FIFO write-side arbiter.
// Holds the FIFO word type, the arbiter state encoding and the round-robin search.
package afifo_pkte;

  localparam int DATA_W    = 8;
  localparam int MAX_NREQ  = 32;
  localparam int IDX_MAXW  = 5;

  typedef logic [DATA_W-1:0] data_ty;

  typedef enum logic {IDLE, OWN} arb_st_e;

  // First set index at or after start (wrapping modulo n), or -1 when none is set.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid, input int start, input int n);
    int idx;
    rr_pick = -1;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[IDX_MAXW-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle seen by the write arbiter.
// slave is the arbiter side, master is the producer/FIFO side.
interface afifo_wr_arbiter_if
  import afifo_pkte::*;
#(
  parameter int NREQ = 4
) ();

  localparam int IDXW = $clog2(NREQ);

  logic   [NREQ-1:0] req_valid;
  data_ty [NREQ-1:0] req_data;
  logic   [NREQ-1:0] req_ready;
  logic              full;
  logic              push;
  data_ty            data_in;
  logic   [IDXW-1:0] grant_id;
  logic              busy;

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, push, data_in, grant_id, busy
  );

  modport master (
    output req_valid, req_data, full,
    input  req_ready, push, data_in, grant_id, busy
  );

endinterface

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin priority picker: first valid index at or after i_start.
module afifo_rr_pick
  import afifo_pkte::*;
#(
  parameter int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDXW-1:0] i_start,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  int w_r;

  assign w_r   = rr_pick(MAX_NREQ'(i_valid), int'(i_start), NREQ);
  assign o_any = (w_r >= 0);
  assign o_idx = IDXW'(w_r);

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async FIFO write port among NREQ
// requesters through a single registered stage that honours full.
module afifo_wr_arbiter
  import afifo_pkte::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 2
) (
  input  logic clk_wr,
  input  logic wr_rst,
  afifo_wr_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int BCW  = $clog2(BURST) + 1;

  typedef logic [IDXW-1:0] idx_t;

  // Explicit wrap so non-power-of-2 NREQ never produces an out-of-range index.
  function automatic idx_t inc_wrap(input idx_t v);
    if (v == idx_t'(NREQ - 1)) return '0;
    return v + idx_t'(1);
  endfunction

  arb_st_e        r_state;
  idx_t           r_owner;
  logic [BCW-1:0] r_bcnt;
  idx_t           r_rr_ptr;
  logic           r_stg_vld;
  data_ty         r_stg_data;
  idx_t           r_stg_id;

  arb_st_e        w_state_nx;
  idx_t           w_owner_nx;
  logic [BCW-1:0] w_bcnt_nx;
  idx_t           w_rr_nx;
  logic           w_stg_vld_nx;
  data_ty         w_stg_data_nx;
  idx_t           w_stg_id_nx;

  logic            w_push;
  logic            w_ld;
  logic            w_owner_vld;
  logic            w_own_cont;
  logic            w_any;
  logic            w_accept;
  idx_t            w_sel;
  idx_t            w_start;
  idx_t            w_pick_idx;
  logic            w_pick_any;
  logic [NREQ-1:0] w_ready;

  // A released owner searches from owner+1 so the next requester is served without a dead cycle.
  assign w_start = (r_state == OWN) ? inc_wrap(r_owner) : r_rr_ptr;

  afifo_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_valid (bus.req_valid),
    .i_start (w_start),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Stage 0 -> stage register: all state lives here.
  always_ff @(posedge clk_wr) begin
    if (wr_rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_bcnt     <= '0;
      r_rr_ptr   <= '0;
      r_stg_vld  <= 1'b0;
      r_stg_data <= '0;
      r_stg_id   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_bcnt     <= w_bcnt_nx;
      r_rr_ptr   <= w_rr_nx;
      r_stg_vld  <= w_stg_vld_nx;
      r_stg_data <= w_stg_data_nx;
      r_stg_id   <= w_stg_id_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_bcnt_nx     = r_bcnt;
    w_rr_nx       = r_rr_ptr;
    w_stg_vld_nx  = r_stg_vld;
    w_stg_data_nx = r_stg_data;
    w_stg_id_nx   = r_stg_id;
    if (w_ld) begin
      w_stg_vld_nx = w_any;
      if ((r_state == OWN) && !w_owner_vld) begin
        w_state_nx = IDLE;
        w_rr_nx    = inc_wrap(r_owner);
      end
      if (w_any) begin
        w_stg_data_nx = bus.req_data[w_sel];
        w_stg_id_nx   = w_sel;
        if (w_own_cont) begin
          w_bcnt_nx = r_bcnt + BCW'(1);
          if (w_bcnt_nx == BCW'(BURST)) begin
            w_state_nx = IDLE;
            w_rr_nx    = inc_wrap(r_owner);
          end
        end else begin
          w_owner_nx = w_sel;
          w_bcnt_nx  = BCW'(1);
          if (BURST > 1) w_state_nx = OWN;
          else           w_rr_nx    = inc_wrap(w_sel);
        end
      end
    end
  end

  always_comb begin
    w_push      = r_stg_vld & ~bus.full & ~wr_rst;
    w_ld        = ~wr_rst & (~r_stg_vld | w_push);
    w_owner_vld = bus.req_valid[r_owner];
    w_own_cont  = (r_state == OWN) & w_owner_vld;
    w_sel       = w_own_cont ? r_owner : w_pick_idx;
    w_any       = w_own_cont | w_pick_any;
    w_accept    = w_ld & w_any;
    w_ready     = w_accept ? (NREQ'(1) << w_sel) : '0;
  end

  assign bus.req_ready = w_ready;
  assign bus.push      = w_push;
  assign bus.data_in   = r_stg_data;
  assign bus.grant_id  = r_stg_id;
  assign bus.busy      = r_stg_vld | (r_state == OWN);

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: BURST=2 and BURST=4 instances share one stimulus stream and
// are compared every cycle against a cycle-level model plus a word scoreboard.
module tb_afifo_wr_arbiter;
  import afifo_pkte::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] valid;
  data_ty [N-1:0] data;
  logic full;

  always #5 clk = ~clk;

  afifo_wr_arbiter_if #(.NREQ(N)) bus2 ();
  afifo_wr_arbiter_if #(.NREQ(N)) bus4 ();

  assign bus2.req_valid = valid;
  assign bus2.req_data  = data;
  assign bus2.full      = full;
  assign bus4.req_valid = valid;
  assign bus4.req_data  = data;
  assign bus4.full      = full;

  afifo_wr_arbiter #(.NREQ(N), .BURST(2)) u_dut2 (.clk_wr(clk), .wr_rst(rst), .bus(bus2));
  afifo_wr_arbiter #(.NREQ(N), .BURST(4)) u_dut4 (.clk_wr(clk), .wr_rst(rst), .bus(bus4));

  logic [N-1:0] o_ready [2];
  logic         o_push  [2];
  data_ty       o_data  [2];
  logic [1:0]   o_gid   [2];
  logic         o_busy  [2];

  assign o_ready[0] = bus2.req_ready;
  assign o_push[0]  = bus2.push;
  assign o_data[0]  = bus2.data_in;
  assign o_gid[0]   = bus2.grant_id;
  assign o_busy[0]  = bus2.busy;
  assign o_ready[1] = bus4.req_ready;
  assign o_push[1]  = bus4.push;
  assign o_data[1]  = bus4.data_in;
  assign o_gid[1]   = bus4.grant_id;
  assign o_busy[1]  = bus4.busy;

  // Model: stage contents, current burst holder (-1 = nobody), words granted to it, next-start pointer.
  logic   m_vld  [2];
  data_ty m_data [2];
  int     m_id   [2];
  int     m_hold [2];
  int     m_cnt  [2];
  int     m_ptr  [2];

  logic e_push [2];
  logic e_ld   [2];
  logic e_any  [2];
  logic e_cont [2];
  int   e_sel  [2];

  logic [N-1:0] s_ready [2];
  logic         s_push  [2];
  data_ty       s_data  [2];
  logic [1:0]   s_gid   [2];

  data_ty sb0[$];
  data_ty sb1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic int burst_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic model_reset(input int i);
    m_vld[i]  = 1'b0;
    m_data[i] = '0;
    m_id[i]   = 0;
    m_hold[i] = -1;
    m_cnt[i]  = 0;
    m_ptr[i]  = 0;
    if (i == 0) sb0.delete();
    else        sb1.delete();
  endtask

  task automatic model_eval(input int i);
    int start;
    int j;
    e_push[i] = !rst && m_vld[i] && !full;
    e_ld[i]   = !rst && (!m_vld[i] || e_push[i]);
    e_cont[i] = (m_hold[i] >= 0) && valid[m_hold[i]];
    e_any[i]  = 1'b0;
    e_sel[i]  = 0;
    if (e_cont[i]) begin
      e_any[i] = 1'b1;
      e_sel[i] = m_hold[i];
    end else begin
      start = (m_hold[i] >= 0) ? (m_hold[i] + 1) % N : m_ptr[i];
      for (int k = 0; k < N; k++) begin
        j = (start + k) % N;
        if (!e_any[i] && valid[j]) begin
          e_any[i] = 1'b1;
          e_sel[i] = j;
        end
      end
    end
  endtask

  task automatic check_out(input int i);
    logic [N-1:0] er;
    string nm;
    nm = (i == 0) ? "b2" : "b4";
    er = '0;
    if (e_ld[i] && e_any[i]) er[e_sel[i]] = 1'b1;
    s_ready[i] = o_ready[i];
    s_push[i]  = o_push[i];
    s_data[i]  = o_data[i];
    s_gid[i]   = o_gid[i];
    chk({nm, "_req_ready"}, 32'(o_ready[i]), 32'(er));
    chk({nm, "_push"},      32'(o_push[i]),  32'(e_push[i]));
    chk({nm, "_data_in"},   32'(o_data[i]),  32'(m_data[i]));
    chk({nm, "_grant_id"},  32'(o_gid[i]),   32'(m_id[i]));
    chk({nm, "_busy"},      32'(o_busy[i]),  32'(m_vld[i] || (m_hold[i] >= 0)));
    if (o_push[i]) begin
      if (i == 0) begin
        chk({nm, "_sb_avail"}, 32'(sb0.size() != 0), 1);
        if (sb0.size() != 0) begin
          chk({nm, "_sb_word"}, 32'(o_data[i]), 32'(sb0[0]));
          void'(sb0.pop_front());
        end
      end else begin
        chk({nm, "_sb_avail"}, 32'(sb1.size() != 0), 1);
        if (sb1.size() != 0) begin
          chk({nm, "_sb_word"}, 32'(o_data[i]), 32'(sb1[0]));
          void'(sb1.pop_front());
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      if (o_ready[i][j] && valid[j]) begin
        if (i == 0) sb0.push_back(data[j]);
        else        sb1.push_back(data[j]);
      end
    end
  endtask

  task automatic model_update(input int i);
    if (rst) begin
      model_reset(i);
    end else if (e_ld[i]) begin
      if ((m_hold[i] >= 0) && !valid[m_hold[i]]) begin
        m_ptr[i]  = (m_hold[i] + 1) % N;
        m_hold[i] = -1;
      end
      if (e_any[i]) begin
        m_vld[i]  = 1'b1;
        m_data[i] = data[e_sel[i]];
        m_id[i]   = e_sel[i];
        if (e_cont[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == burst_of(i)) begin
            m_ptr[i]  = (m_hold[i] + 1) % N;
            m_hold[i] = -1;
          end
        end else begin
          m_cnt[i] = 1;
          if (burst_of(i) > 1) m_hold[i] = e_sel[i];
          else                 m_ptr[i]  = (e_sel[i] + 1) % N;
        end
      end else begin
        m_vld[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_eval(i);
      check_out(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
  endtask

  task automatic rst_cycle();
    rst   = 1'b1;
    valid = '0;
    full  = 1'b0;
    cycle();
    rst   = 1'b0;
  endtask

  int fair_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    rst   = 1'b1;
    valid = '0;
    full  = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset(0);
    model_reset(1);

    // Reset held two cycles with every requester asking.
    rst   = 1'b1;
    valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < N; j++) data[j] = 8'($urandom);
      cycle();
      chk("rst_push",  32'(s_push[0]),  0);
      chk("rst_ready", 32'(s_ready[0]), 0);
      chk("rst_data",  32'(s_data[0]),  0);
    end
    rst = 1'b0;
    cycle();
    chk("rst_first_grant_b2", 32'(s_ready[0]), 32'h1);
    chk("rst_first_grant_b4", 32'(s_ready[1]), 32'h1);
    valid = '0;
    repeat (2) cycle();

    // Single continuous stream from requester 2.
    valid = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      data[2] = 8'(8'hA0 + c);
      cycle();
      chk("stream_ready", 32'(s_ready[0]), 32'h4);
      if (c > 0) begin
        chk("stream_push", 32'(s_push[0]), 1);
        chk("stream_data", 32'(s_data[0]), 32'(8'hA0 + c - 1));
      end
    end
    valid = '0;
    cycle();
    chk("stream_last_push", 32'(s_push[0]), 1);
    chk("stream_last_data", 32'(s_data[0]), 32'hA7);
    cycle();

    // Fairness on the BURST=2 instance.
    rst_cycle();
    valid = 4'hF;
    for (int c = 0; c < 11; c++) begin
      for (int j = 0; j < N; j++) data[j] = 8'($urandom);
      cycle();
      if (c >= 1) chk("fair_grant_id", 32'(s_gid[0]), 32'(fair_exp[c-1]));
    end
    valid = '0;
    cycle();

    // Backpressure: hold 8'h55 under full, then release.
    rst_cycle();
    valid   = 4'b0001;
    data[0] = 8'h55;
    cycle();
    valid = 4'hF;
    full  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < N; j++) data[j] = 8'($urandom);
      cycle();
      chk("bp_push",  32'(s_push[0]),  0);
      chk("bp_data",  32'(s_data[0]),  32'h55);
      chk("bp_ready", 32'(s_ready[0]), 0);
    end
    full = 1'b0;
    cycle();
    chk("bp_release_push",  32'(s_push[0]), 1);
    chk("bp_release_data",  32'(s_data[0]), 32'h55);
    chk("bp_release_ready", 32'(s_ready[0] != '0), 1);
    valid = '0;
    repeat (2) cycle();
    chk("bp_sb_drained", 32'(sb0.size()), 0);

    // Early release on the BURST=4 instance.
    rst_cycle();
    valid = 4'b0001;
    cycle();
    chk("early_req0", 32'(s_ready[1]), 32'h1);
    valid = 4'b1000;
    cycle();
    chk("early_req3_next", 32'(s_ready[1]), 32'h8);
    valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("early_burst3", 32'(s_ready[1]), 32'h8);
    end
    cycle();
    chk("early_burst_end", 32'(s_ready[1]), 32'h1);
    valid = '0;
    cycle();

    // Reset while requester 2 owns a burst and its word is staged.
    rst_cycle();
    valid   = 4'b0100;
    data[2] = 8'h77;
    cycle();
    rst   = 1'b1;
    valid = 4'hF;
    data  = '{8'h44, 8'h33, 8'h22, 8'h11};
    cycle();
    chk("midrst_push",  32'(s_push[0]),  0);
    chk("midrst_ready", 32'(s_ready[0]), 0);
    rst = 1'b0;
    cycle();
    chk("midrst_restart", 32'(s_ready[0]), 32'h1);
    chk("midrst_no_push", 32'(s_push[0]),  0);
    valid = '0;
    cycle();
    chk("midrst_word", 32'(s_data[0]), 32'h11);

    // Randomised traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 39) == 0);
      valid = 4'($urandom);
      full  = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < N; j++) data[j] = 8'($urandom);
      cycle();
    end
    rst   = 1'b0;
    full  = 1'b0;
    valid = '0;
    repeat (2) cycle();
    chk("final_sb_b2", 32'(sb0.size()), 0);
    chk("final_sb_b4", 32'(sb1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arbiter.md
# afifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO. It shares the FIFO write port among `NREQ` independent requesters using round-robin arbitration with a bounded burst length. A single registered output stage drives the FIFO `push`/`data_in` pins and honours `full` without losing or duplicating words. It sits entirely in the write clock domain, between the producer blocks and the FIFO's write-side signals.

## Interface
- `NREQ`, default 4: number of requesters, ≥2.
- `BURST`, default 2: maximum consecutive accepts granted to one owner, ≥1.
- `clk_wr`  in  1: write-domain clock. One clock; every register uses the rising edge.
- `wr_rst`  in  1: synchronous, active-high reset. It is the same net that drives the FIFO's `wr_rst`.
- `req_valid`  in  NREQ: per-requester word-available flag.
- `req_data`  in  NREQ × `data_ty`: per-requester data, packed array indexed by requester.
- `req_ready`  out  NREQ: one-hot or zero. The word is accepted on an edge where `req_valid[i] & req_ready[i]`.
- `full`  in  1: FIFO full flag.
- `push`  out  1: FIFO write strobe.
- `data_in`  out  `data_ty`: FIFO write data.
- `grant_id`  out  $clog2(NREQ): index of the requester whose word sits in the stage.
- `busy`  out  1: stage holds a word, or an owner is locked.

## Operation
- **Output stage registers:** `stg_vld`, `stg_data`, `stg_id`.
- **Outputs from the stage:**
  - `push = stg_vld & ~full` (combinational on `full`).
  - `data_in = stg_data`.
  - `grant_id = stg_id`.
- **Load enable:** `ld = ~wr_rst & (~stg_vld | push)`. When `ld=0`, `req_ready` is all zero.
- **Accept:** when `ld=1`, at most one `req_ready[i]` is set, for the selected requester `sel` with `req_valid[sel]=1`. At the edge, `stg_data<=req_data[sel]`, `stg_id<=sel`, `stg_vld<=1`.
- **Stage drains:** if `ld=1` and no request is valid, `stg_vld<=0` at the edge (a push frees the stage).
- **State machine (`IDLE`, `OWN`), register `owner`, counter `bcnt` of width $clog2(BURST)+1:**
  - **IDLE:** `sel` is the first index with `req_valid` set, searching `rr_ptr, rr_ptr+1, …` modulo `NREQ`. On accept: `owner<=sel`, `bcnt<=1`. Go to `OWN` if `BURST>1`; otherwise stay in `IDLE` with `rr_ptr<=sel+1` (mod `NREQ`).
  - **OWN with `req_valid[owner]` and `bcnt<BURST`:** `sel=owner`. On accept, `bcnt++`. If `bcnt` reaches `BURST`: `rr_ptr<=owner+1`, go to `IDLE`.
  - **OWN with `req_valid[owner]=0`:** release in the same cycle. `rr_ptr<=owner+1`, and arbitrate as in `IDLE`, starting the search at `owner+1`, so there is no dead cycle.
  - **OWN with `ld=0`:** hold `owner` and `bcnt`. The burst count advances only on accepts.
- **Pointer wrap:** `rr_ptr` and all index arithmetic wrap modulo `NREQ`. The wrap is explicit for non-power-of-2 `NREQ`.
- **Boundary conditions:**
  - `full` held high: the stage holds its word indefinitely, `data_in` is stable, `push=0`.
  - `full` falling with the stage valid: `push=1` in that cycle, and a new accept in the same cycle.
  - Simultaneous `push` and accept: the stage is replaced seamlessly, giving a throughput of 1 word/cycle.
- **Reset (sync, any time, including mid-burst):**
  - Cleared: `stg_vld=0`, `stg_data=0`, `stg_id=0`, `owner=0`, `bcnt=0`, `rr_ptr=0`, state `IDLE`.
  - Any staged word is discarded.
  - During the reset cycle, `push=0` and `req_ready=0` regardless of the other inputs.

## Timing
- **Reset values:**
  - `push=0`, `data_in=0`, `grant_id=0`, `req_ready=0`, `busy=0`.
  - `req_ready` may assert in the first cycle after `wr_rst` is released.
- **Latency:** a word accepted at edge N appears on `data_in` with `push=1` in cycle N+1 when `full=0`.
- **Combinational paths:**
  - `full`→`push`.
  - `full`→`req_ready`.
  - `req_valid`→`req_ready`.
  - No path from `req_data` to any output.
- **Throughput:** 1 word/cycle sustained while `full=0`.

## Structure
- **Package `afifo_pkte`:**
  - `data_ty` is taken from it.
  - Add a typedef `arb_st_e {IDLE, OWN}`.
  - Add a function `rr_pick(valid, start)` that returns the first set index at or after `start`, with wrap.
- **Sub-module `afifo_rr_pick`:** combinational round-robin priority picker (inputs `valid`, `start`; outputs `idx`, `any`). The state machine, counter and stage remain in `afifo_wr_arbiter`.

## Test plan
- **Reset:** `wr_rst=1` for 2 cycles with `req_valid=4'hF`, `full=0` → `push=0`, `req_ready=0`, `data_in=0` throughout. The first accept after release goes to requester 0.
- **Single stream:** `req_valid=4'b0100` continuously, `req_data[2]=8'hA0..8'hA7`, `full=0` → `req_ready=4'b0100` every cycle. `push` is high from the cycle after the first accept, and `data_in` carries A0..A7 in order with no gaps.
- **Fairness (`BURST=2`):** `req_valid=4'hF` continuously → `grant_id` sequence 0,0,1,1,2,2,3,3,0,0.
- **Backpressure:** the stage holds 8'h55 and `full=1` for 5 cycles → `push=0`, `data_in=8'h55` stable, `req_ready=0`. When `full` falls, `push=1` and a `req_ready` bit is set in that same cycle. No word is lost or duplicated (scoreboard count matches).
- **Early release (`BURST=4`):** req0 is valid for 1 word then drops, req3 is valid → req3 is accepted in the very next cycle, and its burst then runs for 4 words.
- **Reset mid-burst:** `wr_rst` is pulsed while the stage is valid and `owner=2`, `bcnt=1` → in the reset cycle, `push=0` and `req_ready=0`. After release, the staged word never appears, and arbitration restarts at index 0.
